// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and widths for the cache memory arbiter
// Purpose: state enum, bus widths and the latched request record.
// Ports:   none (package).
package cache_arb_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              we;
    logic [BE_W-1:0]   be;
  } arb_req_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - requester and memory bus bundle for the arbiter
// Purpose: groups the per-requester request/response lines and the shared
//          memory port into one bundle.
// Ports:   slave  - arbiter view (requests and memory responses in, grants,
//                   responses and memory request out)
//          master - environment view (the opposite directions)
interface cache_mem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import cache_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*WORD_W-1:0] addr_i;
  logic [NUM_REQ*WORD_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]        we_i;
  logic [NUM_REQ*BE_W-1:0]   be_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        rvalid_o;
  logic [WORD_W-1:0]         rdata_o;
  logic                      error_o;

  logic                      mem_req_o;
  logic [WORD_W-1:0]         mem_addr_o;
  logic [WORD_W-1:0]         mem_wdata_o;
  logic                      mem_we_o;
  logic [BE_W-1:0]           mem_be_o;
  logic [WORD_W-1:0]         mem_rdata_i;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic                      mem_error_i;

  modport slave (
    input  req_i, addr_i, wdata_i, we_i, be_i,
    output gnt_o, rvalid_o, rdata_o, error_o,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    input  mem_rdata_i, mem_gnt_i, mem_rvalid_i, mem_error_i
  );

  modport master (
    output req_i, addr_i, wdata_i, we_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, error_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    output mem_rdata_i, mem_gnt_i, mem_rvalid_i, mem_error_i
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Purpose: selects the first active request at or after the priority pointer.
// Ports:   req       - request vector
//          ptr       - index of the highest-priority requester
//          grant     - one-hot winner, zero when nothing requests
//          grant_idx - binary index of the winner (0 when nothing requests)
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // Walk from the pointer, wrapping modulo NUM_REQ; first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        grant[IDX_W'(idx)]   = 1'b1;
        grant_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin sharing of one req/gnt/rvalid memory port
// Purpose: arbitrates NUM_REQ cache controllers onto a single memory port with
//          one outstanding transaction and a response watchdog.
// Ports:   clk   - clock
//          rst_n - asynchronous active-low reset
//          bus   - requester side (req/addr/wdata/we/be in, gnt/rvalid/rdata/
//                  error out) and memory side (mem_* request out, mem_*
//                  response in)
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // A zero timeout disables the watchdog; keep the counter at least 1 bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, next_ptr;
  arb_req_t           op_q, op_d, win_op;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               expire;

  logic [NUM_REQ-1:0] gnt, rvalid;
  logic [WORD_W-1:0]  rdata;
  logic               error;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (bus.req_i),
    .ptr       (ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx)
  );

  always_comb begin
    win_op.addr  = bus.addr_i[WORD_W*int'(win_idx) +: WORD_W];
    win_op.wdata = bus.wdata_i[WORD_W*int'(win_idx) +: WORD_W];
    win_op.we    = bus.we_i[win_idx];
    win_op.be    = bus.be_i[BE_W*int'(win_idx) +: BE_W];
  end

  // Priority moves to the requester after the one that just completed.
  assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // cnt_q counts WAIT cycles already spent, so this cycle is number cnt_q+1.
  assign expire = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    rvalid  = '0;
    rdata   = '0;
    error   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|win_grant) begin
          owner_d = win_idx;
          op_d    = win_op;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          gnt[owner_q] = 1'b1;
          if (bus.mem_rvalid_i) begin
            rvalid[owner_q] = 1'b1;
            rdata           = bus.mem_rdata_i;
            error           = bus.mem_error_i;
            ptr_d           = next_ptr;
            state_d         = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A genuine response wins over a watchdog expiry in the same cycle.
        if (bus.mem_rvalid_i) begin
          rvalid[owner_q] = 1'b1;
          rdata           = bus.mem_rdata_i;
          error           = bus.mem_error_i;
          ptr_d           = next_ptr;
          state_d         = IDLE;
        end else if (expire) begin
          rvalid[owner_q] = 1'b1;
          error           = 1'b1;
          ptr_d           = next_ptr;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = rdata;
  assign bus.error_o     = error;
  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_addr_o  = op_q.addr;
  assign bus.mem_wdata_o = op_q.wdata;
  assign bus.mem_we_o    = op_q.we;
  assign bus.mem_be_o    = op_q.be;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares a single PULPino-style memory port (req/gnt/rvalid) between `NUM_REQ` cache controllers, e.g. instruction and data `set_associative_cache` instances. Each transaction is won by round-robin arbitration, the winner's request is latched and forwarded, and the response is routed back to the owner. Only one transaction is outstanding at a time. A response watchdog converts a hung memory access into an error response.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `mem_rvalid_i`; 0 disables the watchdog.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_i`  in  NUM_REQ  per-requester request.
- `addr_i`  in  NUM_REQ*32  request addresses, packed; requester r uses bits [32r+31:32r].
- `wdata_i`  in  NUM_REQ*32  write data, packed the same way.
- `we_i`  in  NUM_REQ  write enable.
- `be_i`  in  NUM_REQ*4  byte enables, packed.
- `gnt_o`  out  NUM_REQ  per-requester grant.
- `rvalid_o`  out  NUM_REQ  per-requester response valid.
- `rdata_o`  out  32  response data, broadcast to all requesters.
- `error_o`  out  1  response error, qualified by `rvalid_o`.
- `mem_addr_o`, `mem_wdata_o`  out  32 each; `mem_we_o`  out  1; `mem_be_o`  out  4; `mem_req_o`  out  1.
- `mem_rdata_i`  in  32; `mem_gnt_i`, `mem_rvalid_i`, `mem_error_i`  in  1 each.

## Operation
- States:
  - IDLE: any `req_i` bit set → pick a winner, latch its index into `owner` and its addr/wdata/we/be, go to REQ. No request → stay.
  - REQ: `mem_req_o`=1, memory outputs driven from the latched registers. On `mem_gnt_i`: `gnt_o[owner]`=1, go to WAIT. If `mem_gnt_i` and `mem_rvalid_i` arrive in the same cycle, deliver both and go to IDLE.
  - WAIT: `mem_req_o`=0. On `mem_rvalid_i`: `rvalid_o[owner]`=1, `rdata_o`=`mem_rdata_i`, `error_o`=`mem_error_i`, go to IDLE. If the watchdog expires first: `rvalid_o[owner]`=1, `rdata_o`=0, `error_o`=1, go to IDLE.
- Round-robin: priority starts at the requester after the previous owner and wraps modulo NUM_REQ. After reset, requester 0 has top priority.
- Priority is updated only on completion (the cycle rvalid is delivered).
- A requester must hold `req_i` and its operands stable until its `gnt_o`. If it drops them early, the latched transaction still completes and its gnt/rvalid are still issued.
- Watchdog counter: $clog2(TIMEOUT_CYCLES+1) bits. Cleared on entry to WAIT, incremented each WAIT cycle, expires when it equals TIMEOUT_CYCLES.
- A late `mem_rvalid_i` arriving in IDLE or REQ after a timeout is ignored: no `rvalid_o` is raised.
- `gnt_o` and `rvalid_o` are one-hot or zero. They are combinational from state, `owner` and the memory inputs.

## Timing
- Reset values: state IDLE, `owner`=0, priority pointer=0, latched operands 0. All outputs 0: `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o`, `gnt_o`, `rvalid_o`, `rdata_o`, `error_o`.
- Latency: `req_i` seen in cycle 0 → `mem_req_o` in cycle 1 → `gnt_o` in the same cycle as `mem_gnt_i` → `rvalid_o` in the same cycle as `mem_rvalid_i`.
- Minimum turnaround: 2 cycles (IDLE, REQ with simultaneous gnt and rvalid).
- The next arbitration happens in the IDLE cycle after completion. Back-to-back transactions therefore have one idle cycle between them.
- `rst_n` asserted mid-transaction aborts immediately to the reset state; no gnt or rvalid is issued.

## Structure
- Package `cache_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, REQ, WAIT);
  - the `WORD_W`=32 and `BE_W`=4 localparams;
  - the `arb_req_t` struct (addr, wdata, we, be).
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs `req`[NUM_REQ] and the pointer; outputs a one-hot `grant` and `grant_idx`. The pointer register lives in the parent.

## Test plan
- Single request: `req_i`=01, addr 0x0000_1000, read; memory gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF → `gnt_o`=01, then `rvalid_o`=01 with `rdata_o`=0xDEADBEEF, `error_o`=0.
- Contention: `req_i`=11 held continuously, six transactions → owners alternate 0,1,0,1,0,1. No `gnt_o` pulse overlaps another requester's open transaction.
- Write forwarding: requester 1 writes addr 0x0000_2004, wdata 0x1234_5678, be 0101 → `mem_we_o`=1, `mem_be_o`=0101 and matching addr/wdata on `mem_*` until `mem_gnt_i`.
- Zero-latency memory: `mem_gnt_i` and `mem_rvalid_i` asserted in the same REQ cycle → `gnt_o` and `rvalid_o` pulse in the same cycle, state returns to IDLE.
- Watchdog: TIMEOUT_CYCLES=4, memory never returns rvalid → `rvalid_o[owner]`=1, `error_o`=1, `rdata_o`=0 on the 4th WAIT cycle. A late `mem_rvalid_i` afterwards produces no `rvalid_o`.
- Reset in WAIT: drop `rst_n` → all outputs 0 asynchronously. After release, the first grant goes to requester 0 when `req_i`=11.
